spi_flash_wb_boot: RTL and testbench

Boot sequencer sitting between an external SPI flash and the user-project Wishbone bus of the management harness. After reset it reads a flat list of 8-byte write records from flash and executes each as a Wishbone write. Writes aimed at a local status address drive the 16-bit `checkbits` field (mprj_io[31:16]) that the chip-level bench monitors. It ends at a terminator record.

---
 rtl/spi_flash_wb_boot.sv | 171 +++++++++++++++++
 tb/tb_spi_flash_wb_boot.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_wb_boot.sv
// SPI flash boot sequencer: streams 8-byte {adr,dat} records from flash and replays them as Wishbone writes.
// Define WB_TIMEOUT_EN to add a 256-cycle ack timeout with a sticky error flag.
module spi_flash_wb_boot #(
  parameter int unsigned SCK_DIV   = 2,
  parameter logic [23:0] BOOT_ADDR = 24'h000000,
  parameter logic [31:0] CHK_ADDR  = 32'h2100_0000
) (
  input  logic        clock,
  input  logic        resetb,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  output logic [15:0] checkbits,
  output logic        done,
  output logic        error
);
  localparam logic [7:0]  DIV_LAST  = 8'(SCK_DIV - 1);
  localparam logic [31:0] HEADER    = {8'h03, BOOT_ADDR};
  localparam logic [31:0] TERM_ADDR = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {RST_WAIT, CMD, ADDR, REC, EXEC, WB, DONE} state_t;

  state_t      state_reg;
  logic [3:0]  wait_cnt_reg;
  logic [7:0]  div_cnt_reg;
  logic [5:0]  bit_cnt_reg;
  logic [31:0] tx_reg;
  logic [63:0] rx_reg;
  logic [31:0] rec_adr;
  logic [31:0] rec_dat;
  logic        sck_tick;
  logic        last_bit;

  // Bytes arrive MSB-first with byte 0 first; both words are little-endian.
  assign rec_adr  = {rx_reg[39:32], rx_reg[47:40], rx_reg[55:48], rx_reg[63:56]};
  assign rec_dat  = {rx_reg[7:0], rx_reg[15:8], rx_reg[23:16], rx_reg[31:24]};
  assign sck_tick = (div_cnt_reg == DIV_LAST);

  always_comb begin
    last_bit = 1'b0;
    case (state_reg)
      CMD:     last_bit = (bit_cnt_reg == 6'd7);
      ADDR:    last_bit = (bit_cnt_reg == 6'd23);
      REC:     last_bit = (bit_cnt_reg == 6'd63);
      default: last_bit = 1'b0;
    endcase
  end

`ifdef WB_TIMEOUT_EN
  logic [7:0] to_cnt_reg;
  logic       error_reg;
  assign error = error_reg;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_reg    <= RST_WAIT;
      wait_cnt_reg <= 4'd0;
      div_cnt_reg  <= 8'd0;
      bit_cnt_reg  <= 6'd0;
      tx_reg       <= 32'd0;
      rx_reg       <= 64'd0;
      flash_csb    <= 1'b1;
      flash_clk    <= 1'b0;
      flash_io0    <= 1'b0;
      wbm_cyc_o    <= 1'b0;
      wbm_stb_o    <= 1'b0;
      wbm_we_o     <= 1'b0;
      wbm_adr_o    <= 32'd0;
      wbm_dat_o    <= 32'd0;
      wbm_sel_o    <= 4'h0;
      checkbits    <= 16'h0000;
      done         <= 1'b0;
`ifdef WB_TIMEOUT_EN
      to_cnt_reg   <= 8'd0;
      error_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        RST_WAIT: begin
          wait_cnt_reg <= wait_cnt_reg + 4'd1;
          if (wait_cnt_reg == 4'd15) begin
            flash_csb   <= 1'b0;
            flash_io0   <= HEADER[31];
            tx_reg      <= HEADER;
            div_cnt_reg <= 8'd0;
            bit_cnt_reg <= 6'd0;
            state_reg   <= CMD;
          end
        end
        CMD, ADDR, REC: begin
          if (!sck_tick) begin
            div_cnt_reg <= div_cnt_reg + 8'd1;
          end else begin
            div_cnt_reg <= 8'd0;
            flash_clk   <= ~flash_clk;
            if (!flash_clk) begin
              if (state_reg == REC) rx_reg <= {rx_reg[62:0], flash_io1};
            end else begin
              // Falling edge: MOSI advances while SCK is low.
              bit_cnt_reg <= last_bit ? 6'd0 : bit_cnt_reg + 6'd1;
              tx_reg      <= {tx_reg[30:0], 1'b0};
              flash_io0   <= (state_reg == CMD || (state_reg == ADDR && !last_bit)) ? tx_reg[30] : 1'b0;
              if (last_bit) begin
                state_reg <= (state_reg == CMD) ? ADDR : (state_reg == ADDR) ? REC : EXEC;
              end
            end
          end
        end
        EXEC: begin
          if (rec_adr == TERM_ADDR) begin
            flash_csb <= 1'b1;
            done      <= 1'b1;
            state_reg <= DONE;
          end else if (rec_adr == CHK_ADDR) begin
            checkbits <= rec_dat[15:0];
            state_reg <= REC;
          end else begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b1;
            wbm_adr_o <= rec_adr;
            wbm_dat_o <= rec_dat;
            wbm_sel_o <= 4'hF;
`ifdef WB_TIMEOUT_EN
            to_cnt_reg <= 8'd0;
`endif
            state_reg <= WB;
          end
        end
        WB: begin
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= 32'd0;
            wbm_dat_o <= 32'd0;
            wbm_sel_o <= 4'h0;
            state_reg <= REC;
          end
`ifdef WB_TIMEOUT_EN
          else if (to_cnt_reg == 8'hFF) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= 32'd0;
            wbm_dat_o <= 32'd0;
            wbm_sel_o <= 4'h0;
            error_reg <= 1'b1;
            state_reg <= REC;
          end else begin
            to_cnt_reg <= to_cnt_reg + 8'd1;
          end
`endif
        end
        DONE: state_reg <= DONE;
        default: state_reg <= RST_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_flash_wb_boot.sv
// Bench for spi_flash_wb_boot: behavioural SPI flash + Wishbone slave, record-level expectation queues.
module tb_spi_flash_wb_boot;
  localparam int          SCK_DIV = 2;
  localparam logic [31:0] CHK     = 32'h2100_0000;
  localparam logic [31:0] TERM    = 32'hFFFF_FFFF;
  localparam logic [91:0] RST_VEC = {1'b1, 91'd0};

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        flash_csb, flash_clk, flash_io0;
  logic        flash_io1 = 1'b0;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i = 1'b0;
  logic [15:0] checkbits;
  logic        done, error;

  always #5 clock = ~clock;

  spi_flash_wb_boot #(.SCK_DIV(SCK_DIV), .BOOT_ADDR(24'h000000), .CHK_ADDR(CHK)) dut (
    .clock(clock), .resetb(resetb),
    .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io0(flash_io0), .flash_io1(flash_io1),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_ack_i(wbm_ack_i),
    .checkbits(checkbits), .done(done), .error(error)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [91:0] outs();
    return {flash_csb, flash_clk, flash_io0, wbm_cyc_o, wbm_stb_o, wbm_we_o,
            wbm_adr_o, wbm_dat_o, wbm_sel_o, checkbits, done, error};
  endfunction

  // Scenario description and the expectations derived from it
  logic [63:0] recs[$];
  int          waits[$];
  logic [63:0] exp_wb[$];
  logic [15:0] exp_chk[$];
  int          wait_q[$];
  logic [7:0]  mem [0:255];

  task automatic load_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    foreach (recs[r]) begin
      for (int b = 0; b < 4; b++) begin
        mem[8*r + b]     = recs[r][32 + 8*b +: 8];
        mem[8*r + 4 + b] = recs[r][8*b +: 8];
      end
    end
  endtask

  task automatic build_expect();
    int  k = 0;
    bit  ended = 0;
    exp_wb.delete(); exp_chk.delete(); wait_q.delete();
    for (int i = 0; i < recs.size(); i++) begin
      if (!ended) begin
        if (recs[i][63:32] == TERM) ended = 1;
        else if (recs[i][63:32] == CHK) exp_chk.push_back(recs[i][15:0]);
        else begin
          exp_wb.push_back(recs[i]);
          wait_q.push_back(waits[k]);
          k++;
        end
      end
    end
  endtask

  // Behavioural SPI flash: READ command, 24-bit address, then sequential bytes
  int          fl_cnt = 0;
  logic [31:0] fl_hdr = 32'd0;
  int          fl_idx;
  int          fl_a;
  always @(posedge flash_clk) begin
    if (!flash_csb) begin
      if (fl_cnt < 32) fl_hdr = {fl_hdr[30:0], flash_io0};
      fl_cnt++;
    end
  end
  always @(negedge flash_clk) begin
    if (!flash_csb && fl_cnt >= 32) begin
      fl_idx    = fl_cnt - 32;
      fl_a      = (int'(fl_hdr[23:0]) + fl_idx / 8) % 256;
      flash_io1 = mem[fl_a][7 - (fl_idx % 8)];
    end
  end
  always @(posedge flash_csb) begin
    fl_cnt    = 0;
    flash_io1 = 1'b0;
  end

  // Compare process plus Wishbone slave
  int          cyc_n = 0, t_rel = 0, t_low = 0, t_rise = 0, t_bnd = 0;
  int          stb_len = 0, cur_wait = 0, last_len = 0, wb_seen = 0, exp_len;
  logic [63:0] cur_exp = 64'd0;
  logic [63:0] last_wb = 64'd0;
  bit          pending = 0, err_exp = 0, spurious = 0;
  logic        p_resetb = 0, p_csb = 1, p_sck = 0, p_io0 = 0, p_cyc = 0, p_done = 0;
  logic [15:0] p_cb = 16'd0;

  always @(negedge clock) begin
    cyc_n++;
    if (!resetb) begin
      pending = 0;
      err_exp = 0;
      stb_len = 0;
    end else begin
      if (!p_resetb) t_rel = cyc_n;
      if (p_csb && !flash_csb) begin
        chk("csb_fall_latency", cyc_n - t_rel, 16);
        t_low = cyc_n;
      end
      if (!p_sck && flash_clk) begin
        chk("sck_low_len", cyc_n - t_low, SCK_DIV);
        chk("sck_paused_at_record_end", pending, 0);
        t_rise = cyc_n;
      end
      if (p_sck && !flash_clk) begin
        chk("sck_high_len", cyc_n - t_rise, SCK_DIV);
        t_low = cyc_n;
        if (fl_cnt == 32) chk("flash_header", fl_hdr, 32'h0300_0000);
        if (fl_cnt > 32 && (fl_cnt - 32) % 64 == 0) begin
          pending = 1;
          t_bnd   = cyc_n;
        end
      end
      if (flash_io0 !== p_io0) begin
        chk("io0_changes_with_sck_low", flash_clk, 0);
        if (fl_cnt >= 32) chk("io0_zero_outside_header", flash_io0, 0);
      end
      if (!p_cyc && wbm_cyc_o) begin
        chk("wb_start_latency", cyc_n - t_bnd, 1);
        chk("wb_start_pending", pending, 1);
        pending = 0;
        chk("wb_expected", exp_wb.size() > 0, 1);
        cur_exp  = (exp_wb.size() > 0) ? exp_wb.pop_front() : 64'd0;
        cur_wait = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
        stb_len  = 0;
        last_wb  = {wbm_adr_o, wbm_dat_o};
      end
      if (wbm_cyc_o) chk("wb_bus", {wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, {1'b1, 1'b1, 4'hF, cur_exp});
      else           chk("wb_idle", {wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, 70'd0);
      if (p_cyc && !wbm_cyc_o) begin
        exp_len = (cur_wait >= 256) ? 256 : cur_wait + 1;
        chk("wb_strobe_len", stb_len, exp_len);
        last_len = stb_len;
        wb_seen++;
        if (cur_wait >= 256) err_exp = 1;
        t_low = cyc_n;
      end
      if (checkbits !== p_cb) begin
        chk("checkbits_latency", cyc_n - t_bnd, 1);
        chk("checkbits_pending", pending, 1);
        pending = 0;
        chk("checkbits_value", checkbits, (exp_chk.size() > 0) ? exp_chk.pop_front() : p_cb);
        t_low = cyc_n;
      end
      if (!p_done && done) begin
        chk("done_latency", cyc_n - t_bnd, 1);
        chk("done_pending", pending, 1);
        pending = 0;
        chk("done_records_left", exp_wb.size() + exp_chk.size(), 0);
        chk("done_csb_high", flash_csb, 1);
      end
      chk("error_flag", error, err_exp);
    end
    if (wbm_cyc_o && wbm_stb_o) begin
      wbm_ack_i = (stb_len == cur_wait);
      stb_len++;
    end else begin
      wbm_ack_i = spurious && ($urandom_range(0, 3) == 0);
    end
    p_resetb = resetb; p_csb = flash_csb; p_sck = flash_clk; p_io0 = flash_io0;
    p_cyc = wbm_cyc_o; p_done = done; p_cb = checkbits;
  end

  // Extra instances at SCK_DIV 1 and 4; MISO tied high makes the first record a terminator
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_div
    localparam int D = (gi == 0) ? 1 : 4;
    logic        csb, sck, mosi, cy, st, we, dn, er;
    logic [31:0] ad, da;
    logic [3:0]  se;
    logic [15:0] cb;
    int          cnt = 0, lat = -1, nb = 0;
    logic [31:0] hdr = 32'd0;
    logic        p_sck_g = 1'b0;
    spi_flash_wb_boot #(.SCK_DIV(D), .BOOT_ADDR(24'h000000), .CHK_ADDR(CHK)) u_dut (
      .clock(clock), .resetb(resetb),
      .flash_csb(csb), .flash_clk(sck), .flash_io0(mosi), .flash_io1(1'b1),
      .wbm_cyc_o(cy), .wbm_stb_o(st), .wbm_we_o(we), .wbm_adr_o(ad), .wbm_dat_o(da),
      .wbm_sel_o(se), .wbm_ack_i(1'b0), .checkbits(cb), .done(dn), .error(er)
    );
    always @(negedge clock) begin
      if (!resetb) begin
        cnt = 0; lat = -1; nb = 0;
      end else if (!csb) begin
        if (sck && lat < 0) lat = cnt;
        if (sck && !p_sck_g && nb < 32) begin
          hdr = {hdr[30:0], mosi};
          nb++;
        end
        cnt++;
      end
      p_sck_g = sck;
    end
  end

  task automatic start_run();
    load_mem();
    build_expect();
    wb_seen = 0;
    resetb  = 1'b0;
    repeat (3) @(posedge clock);
    #1 chk("reset_outputs", outs(), RST_VEC);
    @(posedge clock);
    #2 resetb = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 20000) begin
      @(posedge clock);
      n++;
    end
    chk({name, "_done"}, done, 1);
    repeat (3) @(posedge clock);
    #1 chk({name, "_end_state"}, {flash_csb, flash_clk, wbm_cyc_o, done}, 4'b1001);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [15:0] last_cb;
    int          n;

    // Two status records then terminator
    recs = '{{CHK, 32'h0000_AB60}, {CHK, 32'h0000_AB6A}, {TERM, 32'h0}};
    waits.delete();
    start_run();
    wait_done("t1");
    chk("t1_checkbits", checkbits, 16'hAB6A);
    chk("t1_wb_count", wb_seen, 0);

    // Single write, slave acks after 3 wait cycles
    recs = '{{32'h3000_0004, 32'h1234_5678}, {TERM, 32'h0}};
    waits = '{3};
    start_run();
    wait_done("t2");
    chk("t2_wb_count", wb_seen, 1);
    chk("t2_wb_word", last_wb, 64'h3000_0004_1234_5678);
    chk("t2_stb_len", last_len, 4);
    chk("t2_checkbits", checkbits, 16'h0000);

    // Reset pulse while record 2 is streaming
    recs = '{{CHK, 32'h0000_AB60}, {CHK, 32'h0000_AB6A}, {TERM, 32'h0}};
    waits.delete();
    start_run();
    n = 0;
    while (fl_cnt < 32 + 64 + 20 && n < 5000) begin
      @(posedge clock);
      n++;
    end
    chk("t3_reached_record2", fl_cnt >= 32 + 64 + 20, 1);
    #3 resetb = 1'b0;
    #1 chk("t3_async_reset", outs(), RST_VEC);
    build_expect();
    repeat (3) @(posedge clock);
    #2 resetb = 1'b1;
    wait_done("t3");
    chk("t3_checkbits", checkbits, 16'hAB6A);

    // Randomized record lists with random ack latency and stray acks
    spurious = 1;
    for (int s = 0; s < 3; s++) begin
      recs.delete();
      waits.delete();
      last_cb = 16'h0000;
      n = $urandom_range(4, 9);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          d = $urandom;
          do d[15:0] = 16'($urandom); while (d[15:0] == last_cb || d[15:0] == 16'h0);
          last_cb = d[15:0];
          recs.push_back({CHK, d});
        end else begin
          a = $urandom;
          if (a == CHK || a == TERM) a = 32'h3000_0000;
          recs.push_back({a, 32'($urandom)});
          waits.push_back($urandom_range(0, 5));
        end
      end
      recs.push_back({TERM, 32'($urandom)});
      start_run();
      wait_done("rand");
      chk("rand_final_checkbits", checkbits, last_cb);
      chk("rand_wb_count", wb_seen, waits.size());
    end
    spurious = 0;

`ifdef WB_TIMEOUT_EN
    // Slave never acks: timeout, then the status record still applies
    recs = '{{32'h3000_0010, 32'hDEAD_BEEF}, {CHK, 32'h0000_AB6A}, {TERM, 32'h0}};
    waits = '{1000};
    start_run();
    wait_done("t5");
    chk("t5_error", error, 1);
    chk("t5_checkbits", checkbits, 16'hAB6A);
    chk("t5_stb_len", last_len, 256);
`endif

    repeat (1500) @(posedge clock);
    #1;
    chk("div1_first_rise", g_div[0].lat, 1);
    chk("div4_first_rise", g_div[1].lat, 4);
    chk("div1_header", g_div[0].hdr, 32'h0300_0000);
    chk("div4_header", g_div[1].hdr, 32'h0300_0000);
    chk("div1_term_first", {g_div[0].dn, g_div[0].csb, g_div[0].cy, g_div[0].cb}, {3'b110, 16'h0000});
    chk("div4_term_first", {g_div[1].dn, g_div[1].csb, g_div[1].cy, g_div[1].cb}, {3'b110, 16'h0000});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
